// File: rtl/rptr_empty_pkg.sv
// ---------------------------------------------------------------------------
// rptr_empty_pkg
// Shared definitions for the asynchronous FIFO pointer logic.
//   ADDRSIZE : RAM address width; FIFO depth is DEPTH = 2**ADDRSIZE.
//   ptr_t    : pointer type with one extra MSB so full and empty differ.
//   addr_t   : RAM address type.
//   bin2gray / gray2bin : pointer code conversions.
// ---------------------------------------------------------------------------
package rptr_empty_pkg;

    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 1 << ADDRSIZE;

    typedef logic [ADDRSIZE:0]   ptr_t;
    typedef logic [ADDRSIZE-1:0] addr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[ADDRSIZE] = gray[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/rptr_empty_gray_ptr_cnt.sv
// ---------------------------------------------------------------------------
// gray_ptr_cnt
// Binary + Gray pointer register with an increment enable. Used by the
// read-side empty controller and reusable by the write-side full controller.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc         : advance the pointer by one this cycle
//   addr        : low ADDRSIZE bits of the registered binary pointer
//   gray_q      : registered Gray pointer
//   bin_next    : binary pointer value being loaded on the next edge
//   gray_next   : Gray pointer value being loaded on the next edge
// ---------------------------------------------------------------------------
module gray_ptr_cnt
    import rptr_empty_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc,
    output addr_t addr,
    output ptr_t  gray_q,
    output ptr_t  bin_next,
    output ptr_t  gray_next
);

    ptr_t bin_q;

    // Modulo 2**(ADDRSIZE+1) increment; wraps naturally through the MSB.
    always_comb begin
        bin_next  = bin_q + ptr_t'(inc);
        gray_next = bin2gray(bin_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
        end
    end

    assign addr = bin_q[ADDRSIZE-1:0];

endmodule

// File: rtl/rptr_empty.sv
// ---------------------------------------------------------------------------
// rptr_empty
// Read-domain pointer and empty-flag controller of the asynchronous FIFO.
// Everything runs on rclk; rq2_wptr must already be synchronised into this
// domain (no synchroniser flops are added here).
// Ports:
//   rclk, rrst_n : read clock, asynchronous active-low reset
//   rinc         : read request from the consumer
//   rq2_wptr     : synchronised Gray write pointer
//   raddr        : binary RAM read address (straight from the register)
//   rptr         : registered Gray read pointer, to the write domain
//   rempty       : registered empty flag
//   raempty      : registered almost-empty flag (tied 0 unless enabled)
//   rvalid       : RAM read data valid, one cycle after an accepted read
//   runderflow   : one-cycle pulse when a read is requested while empty
//   rlevel       : registered fill level, 0..DEPTH
// Build option:
//   FIFO_AEMPTY_EN : when defined, raempty = (level <= AEMPTY_THRESH).
// ---------------------------------------------------------------------------
module rptr_empty
    import rptr_empty_pkg::*;
#(
    parameter int AEMPTY_THRESH = 2
) (
    input  logic  rclk,
    input  logic  rrst_n,
    input  logic  rinc,
    input  ptr_t  rq2_wptr,
    output addr_t raddr,
    output ptr_t  rptr,
    output logic  rempty,
    output logic  raempty,
    output logic  rvalid,
    output logic  runderflow,
    output ptr_t  rlevel
);

    // Elaboration-time range check on the threshold.
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_thresh
        $error("rptr_empty: AEMPTY_THRESH out of range");
    end

    logic rd_ok;
    ptr_t rbin_next;
    ptr_t rgray_next;
    ptr_t wbin;
    ptr_t level_d;
    logic rempty_d, rempty_q;
    logic rvalid_d, rvalid_q;
    logic runderflow_d, runderflow_q;
    ptr_t rlevel_q;

    assign rd_ok = rinc & ~rempty_q;

    gray_ptr_cnt u_ptr (
        .clk       (rclk),
        .rst_n     (rrst_n),
        .inc       (rd_ok),
        .addr      (raddr),
        .gray_q    (rptr),
        .bin_next  (rbin_next),
        .gray_next (rgray_next)
    );

    // Flags are computed from the post-read pointer so that consuming the
    // last entry raises empty on the very next edge. A write pointer that
    // advances in the same cycle is seen only later, so empty can only be
    // late to clear, never early.
    always_comb begin
        wbin         = gray2bin(rq2_wptr);
        level_d      = wbin - rbin_next;
        rempty_d     = (rgray_next == rq2_wptr);
        rvalid_d     = rd_ok;
        runderflow_d = rinc & rempty_q;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rempty_q     <= 1'b1;
            rvalid_q     <= 1'b0;
            runderflow_q <= 1'b0;
            rlevel_q     <= '0;
        end else begin
            rempty_q     <= rempty_d;
            rvalid_q     <= rvalid_d;
            runderflow_q <= runderflow_d;
            rlevel_q     <= level_d;
        end
    end

`ifdef FIFO_AEMPTY_EN
    logic raempty_d, raempty_q;

    always_comb begin
        raempty_d = (level_d <= ptr_t'(AEMPTY_THRESH));
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            raempty_q <= 1'b1;
        end else begin
            raempty_q <= raempty_d;
        end
    end

    assign raempty = raempty_q;
`else
    assign raempty = 1'b0;
`endif

    assign rempty     = rempty_q;
    assign rvalid     = rvalid_q;
    assign runderflow = runderflow_q;
    assign rlevel     = rlevel_q;

endmodule

// File: tb/tb_rptr_empty.sv
// ---------------------------------------------------------------------------
// tb_rptr_empty
// Directed bench for rptr_empty (ADDRSIZE = 4, AEMPTY_THRESH = 2).
// Inputs change just after the falling edge; outputs are checked on the
// falling edge or shortly after an asynchronous reset event.
// ---------------------------------------------------------------------------
module tb_rptr_empty;
    import rptr_empty_pkg::*;

    localparam int THRESH = 2;

    logic  clk;
    logic  rrst_n;
    logic  rinc;
    ptr_t  rq2_wptr;
    addr_t raddr;
    ptr_t  rptr;
    logic  rempty;
    logic  raempty;
    logic  rvalid;
    logic  runderflow;
    ptr_t  rlevel;

    int vectors;
    int miscompares;
    int rb;

    rptr_empty #(.AEMPTY_THRESH(THRESH)) dut (
        .rclk       (clk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rvalid     (rvalid),
        .runderflow (runderflow),
        .rlevel     (rlevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected almost-empty flag for a given fill level in this build.
    function automatic logic exp_ae(input int lvl);
`ifdef FIFO_AEMPTY_EN
        return (lvl <= THRESH);
`else
        return 1'b0 & (lvl == lvl);
`endif
    endfunction

    // Gray encoding of a 5-bit binary pointer, written out independently.
    function automatic ptr_t to_gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return {v[4], v[4] ^ v[3], v[3] ^ v[2], v[2] ^ v[1], v[1] ^ v[0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rempty"},     32'(rempty),     32'd1);
        check({tag, "_rptr"},       32'(rptr),       32'd0);
        check({tag, "_raddr"},      32'(raddr),      32'd0);
        check({tag, "_rlevel"},     32'(rlevel),     32'd0);
        check({tag, "_rvalid"},     32'(rvalid),     32'd0);
        check({tag, "_runderflow"}, 32'(runderflow), 32'd0);
        check({tag, "_raempty"},    32'(raempty),    32'(exp_ae(0)));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rrst_n      = 1'b1;
        rinc        = 1'b0;
        rq2_wptr    = '0;

        // 1. Reset asserted between edges takes effect without a clock.
        #3 rrst_n = 1'b0;
        #1 check_reset_outputs("reset");

        // 2. Three entries available, then three back-to-back reads.
        @(negedge clk);
        rrst_n   = 1'b1;
        rq2_wptr = 5'b00010;
        @(negedge clk);
        check("lvl3_rempty",  32'(rempty),  32'd0);
        check("lvl3_rlevel",  32'(rlevel),  32'd3);
        check("lvl3_raempty", 32'(raempty), 32'(exp_ae(3)));
        check("lvl3_rvalid",  32'(rvalid),  32'd0);
        rinc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rd_raddr", 32'(raddr), 32'(i));
            @(negedge clk);
            check("rd_rvalid", 32'(rvalid), 32'd1);
        end
        check("drain_rempty", 32'(rempty), 32'd1);
        check("drain_rlevel", 32'(rlevel), 32'd0);
        check("drain_rptr",   32'(rptr),   32'h02);

        // 3. rinc still high while empty: one underflow pulse, no movement.
        @(negedge clk);
        check("uf_pulse",  32'(runderflow), 32'd1);
        check("uf_rvalid", 32'(rvalid),     32'd0);
        check("uf_rptr",   32'(rptr),       32'h02);
        check("uf_raddr",  32'(raddr),      32'd3);
        rinc = 1'b0;
        @(negedge clk);
        check("uf_clear", 32'(runderflow), 32'd0);

        // 4. Full level from pointer zero, then 32 reads with writer ahead.
        rrst_n = 1'b0;
        #1 rrst_n = 1'b1;
        rq2_wptr = 5'b11000;
        @(negedge clk);
        check("full_rlevel", 32'(rlevel), 32'd16);
        check("full_rempty", 32'(rempty), 32'd0);
        rinc = 1'b1;
        for (rb = 0; rb < 32; rb++) begin
            check("wrap_raddr",  32'(raddr),  32'(rb % 16));
            check("wrap_rempty", 32'(rempty), 32'd0);
            check("wrap_rlevel", 32'(rlevel), (rb == 0) ? 32'd16 : 32'd15);
            if (rb == 31) check("wrap_rptr31", 32'(rptr), 32'h10);
            rq2_wptr = to_gray(rb + 16);
            @(negedge clk);
        end
        check("wrap_rptr0",   32'(rptr),   32'd0);
        check("wrap_raddr0",  32'(raddr),  32'd0);
        check("wrap_rvalid",  32'(rvalid), 32'd1);
        check("wrap_rlevel_end", 32'(rlevel), 32'd15);

        // 5. Almost-empty walk from level 4 down to 0.
        rinc     = 1'b0;
        rq2_wptr = to_gray(4);
        @(negedge clk);
        check("ae_lvl4", 32'(rlevel),  32'd4);
        check("ae_at4",  32'(raempty), 32'(exp_ae(4)));
        rinc = 1'b1;
        for (int lvl = 3; lvl >= 0; lvl--) begin
            @(negedge clk);
            check("ae_level", 32'(rlevel),  32'(lvl));
            check("ae_flag",  32'(raempty), 32'(exp_ae(lvl)));
        end
        check("ae_empty", 32'(rempty), 32'd1);
        rinc = 1'b0;

        // 6. Reset in the middle of a read stream drops the in-flight rvalid.
        rq2_wptr = to_gray(9);
        @(negedge clk);
        check("mid_lvl5", 32'(rlevel), 32'd5);
        rinc = 1'b1;
        @(posedge clk);
        #2;
        check("mid_rvalid_before", 32'(rvalid), 32'd1);
        rrst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rrst_n   = 1'b1;
        rinc     = 1'b0;
        rq2_wptr = '0;
        @(negedge clk);
        check("post_rempty", 32'(rempty), 32'd1);
        check("post_rlevel", 32'(rlevel), 32'd0);
        @(negedge clk);
        check("post_rempty2", 32'(rempty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rptr_empty.md
Name: rptr_empty

Overview:
Read-domain pointer and empty-flag controller for the asynchronous FIFO, running entirely on rclk. It takes the write pointer after two-flop synchronisation into the read domain (rq2_wptr) and produces:
- the binary RAM read address;
- the Gray read pointer, which is sent back to the write domain;
- registered empty, fill-level, data-valid and underflow indications.

Parameters:
- AEMPTY_THRESH, 2, almost-empty threshold in entries; range 0..2**ADDRSIZE-1. Used only with FIFO_AEMPTY_EN.
- ADDRSIZE is not a parameter: it is taken from package definitions. FIFO depth = 2**ADDRSIZE.

Ports:
- rclk  input  1  read-domain clock
- rrst_n  input  1  asynchronous active-low reset, read domain
- rinc  input  1  read request from consumer
- rq2_wptr  input  ADDRSIZE+1  synchronised Gray write pointer
- raddr  output  ADDRSIZE  binary RAM read address
- rptr  output  ADDRSIZE+1  registered Gray read pointer, to the write-domain synchroniser
- rempty  output  1  registered FIFO-empty flag
- raempty  output  1  registered almost-empty flag
- rvalid  output  1  RAM read data valid
- runderflow  output  1  one-cycle pulse on a read attempted while empty
- rlevel  output  ADDRSIZE+1  registered fill level, 0..2**ADDRSIZE

Behaviour:
- One clock, rclk. Reset rrst_n is asynchronous and active-low.
- Reset values: rbin=0, rptr=0, rempty=1, raempty=1 (0 when FIFO_AEMPTY_EN is undefined), rvalid=0, runderflow=0, rlevel=0.
- Read acceptance:
  - rd_ok = rinc & ~rempty.
  - rbinnext = rbin + rd_ok, modulo 2**(ADDRSIZE+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - rbin and rptr register rbinnext and rgraynext every cycle.
- raddr = rbin[ADDRSIZE-1:0], driven straight from the register. The RAM read is synchronous, one cycle.
- Empty:
  - rempty <= (rgraynext == rq2_wptr).
  - Reading the last entry asserts rempty on the very next edge; there is no extra bubble.
- Level:
  - wbin = gray2bin(rq2_wptr).
  - rlevel <= wbin - rbinnext, ADDRSIZE+1 bits, modulo arithmetic.
  - rlevel==0 holds exactly when rempty==1, every cycle.
  - MSB wrap: a write pointer one lap ahead gives 2**ADDRSIZE (full).
- rvalid <= rd_ok. Data for raddr is valid in the cycle after acceptance. Back-to-back reads produce back-to-back rvalid.
- runderflow <= rinc & rempty. The pointer does not move, rvalid stays 0, and the pulse is not sticky.
- Wrap-around: rbin goes from 2**(ADDRSIZE+1)-1 to 0, rptr goes from Gray(max) to 0, and raddr wraps from 2**ADDRSIZE-1 to 0.
- Write pointer updates while reading (rq2_wptr advancing in the same cycle as rd_ok): both are used as sampled. The empty flag is pessimistic, never optimistic.
- Reset mid-operation: all state clears immediately and asynchronously. An in-flight rvalid is dropped.
- rq2_wptr is treated as a clean Gray code. This block adds no synchroniser flops of its own.

Optional Feature:
- FIFO_AEMPTY_EN defined: raempty <= (wbin - rbinnext) <= AEMPTY_THRESH. It resets to 1.
- FIFO_AEMPTY_EN undefined: raempty is tied to 0, and the comparator and register are absent.

Decomposition:
- Package definitions holds:
  - the existing ADDRSIZE, plus DEPTH = 1<<ADDRSIZE;
  - typedef ptr_t = logic [ADDRSIZE:0];
  - typedef addr_t = logic [ADDRSIZE-1:0];
  - functions bin2gray(ptr_t) and gray2bin(ptr_t). gray2bin is an XOR prefix from the MSB down.
- Natural sub-module: gray_ptr_cnt, a binary+Gray pointer register with an increment enable. It is reusable by the write-side full controller.

Test Plan:
All scenarios use ADDRSIZE=4.
1. Reset: assert rrst_n=0 mid-clock → immediately rempty=1, rptr=5'b00000, raddr=0, rlevel=0, rvalid=0, runderflow=0.
2. Basic reads:
   - Set rq2_wptr=5'b00010 (Gray 3) with rinc=0 → next edge rempty=0, rlevel=3.
   - Then rinc=1 for 3 cycles → raddr=0,1,2; rvalid=1 on cycles 2–4.
   - rempty=1 and rlevel=0 after the 3rd read; rptr=5'b00010.
3. Underflow: with rempty=1, drive rinc=1 for one cycle → runderflow=1 for exactly one cycle; rptr and raddr unchanged; rvalid=0.
4. Full level and wrap:
   - With rbin=0, set rq2_wptr=5'b11000 (Gray 16) → rlevel=16, rempty=0.
   - Keep the write pointer ahead and read 32 entries → rptr goes 5'b10000 (Gray 31) → 5'b00000; raddr goes 15→0; no spurious rempty.
5. Almost-empty, FIFO_AEMPTY_EN defined, AEMPTY_THRESH=2: from level 4, read one per cycle → raempty=0 at levels 4 and 3; raempty=1 at levels 2, 1, 0. With the macro undefined, raempty stays 0 throughout.
6. Reset mid-stream: at level 5 with rinc=1, assert rrst_n=0 → all outputs return to reset values; after release with rq2_wptr=0, rempty stays 1.
